spi_master_seq: RTL and testbench
=================================

Name: spi_master_seq

Overview:
Transfer sequencer for the SPI master SCK path. On a start request it generates the baud-rate toggle (M_BaudRate) and the idle gating that the SCK control stage consumes, and it frames the transfer with SS_n. It also runs the bit counter, the MOSI shift register and the MISO capture register. All work is done in the single system clock domain, using edge strobes rather than derived clocks.

Parameters:
DATA_W, 8, bits per transfer, MSB first
DIV_W, 8, width of the baud divider input

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  transfer request; sampled only in IDLE
tx_data  input  DATA_W  byte to transmit; latched on accepted start
BaudDiv  input  DIV_W  half-SCK period minus 1, in clk cycles; latched on accepted start
CPOL  input  1  clock polarity; latched on accepted start
CPHA  input  1  clock phase; latched on accepted start
MISO  input  1  serial data in
M_BaudRate  output  1  raw baud toggle to SCK control; 0 outside XFER
idle  output  1  to SCK control; 1 in every state except XFER
SCK  output  1  pin clock: CPOL_l ^ M_BaudRate during XFER, CPOL_l otherwise
MOSI  output  1  MSB of tx shift register; 0 in IDLE
SS_n  output  1  slave select, active low
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when transfer completes
rx_data  output  DATA_W  last received byte; held until the next done

Behaviour:
- Reset values: M_BaudRate=0, idle=1, SCK=0, MOSI=0, SS_n=1, busy=0, done=0, rx_data=0. The FSM goes to IDLE and all counters clear. Reset mid-transfer aborts the transfer the next cycle, with no done pulse.
- FSM states: IDLE, SETUP, XFER, HOLD.
- IDLE -> SETUP on start=1:
  - latch tx_data into tx_sreg, and latch BaudDiv/CPOL/CPHA into the _l copies;
  - SS_n goes low in the first SETUP cycle (1 cycle after start);
  - start while busy is ignored and no state is altered.
- Baud counter:
  - counts 0..BaudDiv_l and wraps;
  - a tick occurs on the wrap cycle, so every BaudDiv_l+1 clk cycles;
  - BaudDiv=0 gives a tick every cycle;
  - the counter is cleared on every state entry.
- SETUP: lasts exactly one half period (BaudDiv_l+1 cycles) with MOSI = tx_data MSB. On the tick it goes to XFER.
- XFER:
  - each tick toggles M_BaudRate and increments edge_cnt (0..2*DATA_W-1);
  - an edge is leading when M_BaudRate goes 0->1 and trailing when it goes 1->0;
  - after 2*DATA_W edges (M_BaudRate back to 0) it goes to HOLD.
- CPHA_l=0 edge actions:
  - leading edge samples: rx_sreg <= {rx_sreg[DATA_W-2:0], MISO};
  - trailing edge shifts tx_sreg left by 1, except on the final trailing edge.
- CPHA_l=1 edge actions:
  - leading edge shifts tx_sreg left, except on the first leading edge;
  - trailing edge samples MISO into rx_sreg.
- Edge counts per transfer: exactly DATA_W sample edges and DATA_W-1 shifts.
- HOLD:
  - lasts one half period; SS_n stays low and SCK = CPOL_l;
  - on its tick: go to IDLE, SS_n=1, done=1 for one cycle, rx_data <= rx_sreg (updated in the same cycle as done).
- Timing: SS_n low for exactly (2*DATA_W+2)*(BaudDiv_l+1) cycles. The next start is accepted in the same cycle as done.
- Input changes: changing CPOL/CPHA/BaudDiv inputs mid-transfer has no effect, because only the latched copies are used.

Test Plan:
- Mode 0 loopback: CPOL=0, CPHA=0, BaudDiv=0, MISO=MOSI, tx_data=0xA5, start 1 cycle.
  - SS_n low 18 cycles;
  - 8 SCK rising edges, SCK idles 0;
  - done 1 cycle, rx_data=0xA5.
- Mode 1: CPOL=0, CPHA=1, BaudDiv=1, tx_data=0x3C, MISO driven 0xC3 MSB-first (changes on leading edge).
  - MOSI stable across every trailing edge and equals the 0x3C bits;
  - rx_data=0xC3;
  - SS_n low 36 cycles.
- Modes 2/3: CPOL=1, CPHA=0, then CPHA=1, tx_data=0x81, loopback.
  - SCK idles 1 before and after the transfer;
  - 8 falling leading edges;
  - rx_data=0x81 both times.
- Divider timing: BaudDiv=3, mode 0.
  - SCK half period = 4 cycles;
  - SS_n low 72 cycles;
  - idle=0 only during the 64 XFER cycles.
- start pulses held high throughout busy, with a BaudDiv/CPOL change mid-transfer.
  - first transfer unaffected;
  - second transfer begins on the done cycle using the new values.
- rst=1 at edge 5 of a transfer.
  - next cycle: SS_n=1, idle=1, M_BaudRate=0, busy=0, rx_data=0;
  - no done pulse.

Source files
------------

// File: rtl/spi_master_seq.sv
// SPI master transfer sequencer: baud toggle, SS_n framing, bit shifting and capture.
// Everything runs on clk; the baud divider produces edge strobes instead of a derived clock.
module spi_master_seq #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [DIV_W-1:0]  BaudDiv,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              MISO,
    output logic              M_BaudRate,
    output logic              idle,
    output logic              SCK,
    output logic              MOSI,
    output logic              SS_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W - 1);

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]  baud_div_q, baud_div_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [EW-1:0]     edge_cnt_q, edge_cnt_d;
    logic              mbr_q, mbr_d;
    logic [DATA_W-1:0] tx_sreg_q, tx_sreg_d;
    logic [DATA_W-1:0] rx_sreg_q, rx_sreg_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              done_q, done_d;
    logic              ss_n_q, ss_n_d;
    logic              idle_q, idle_d;
    logic              busy_q, busy_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              tick_s;

    // Next-state logic: FSM, baud divider, edge actions and next values of the output flops.
    always_comb begin
        state_d    = state_q;
        baud_div_d = baud_div_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        edge_cnt_d = edge_cnt_q;
        mbr_d      = mbr_q;
        tx_sreg_d  = tx_sreg_q;
        rx_sreg_d  = rx_sreg_q;
        rx_data_d  = rx_data_q;
        done_d     = 1'b0;
        tick_s     = (div_cnt_q == baud_div_q);
        div_cnt_d  = tick_s ? {DIV_W{1'b0}} : div_cnt_q + DIV_W'(1);

        case (state_q)
            S_IDLE: begin
                div_cnt_d = {DIV_W{1'b0}};
                if (start) begin
                    state_d    = S_SETUP;
                    tx_sreg_d  = tx_data;
                    baud_div_d = BaudDiv;
                    cpol_d     = CPOL;
                    cpha_d     = CPHA;
                    edge_cnt_d = {EW{1'b0}};
                    mbr_d      = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (tick_s) begin
                    state_d = S_XFER;
                end else begin
                    state_d = S_SETUP;
                end
            end
            S_XFER: begin
                if (tick_s) begin
                    mbr_d      = ~mbr_q;
                    edge_cnt_d = edge_cnt_q + EW'(1);
                    // mbr_q low means this tick is a leading edge
                    if (!mbr_q) begin
                        if (!cpha_q) begin
                            rx_sreg_d = {rx_sreg_q[DATA_W-2:0], MISO};
                        end else if (edge_cnt_q != {EW{1'b0}}) begin
                            tx_sreg_d = {tx_sreg_q[DATA_W-2:0], 1'b0};
                        end else begin
                            tx_sreg_d = tx_sreg_q;
                        end
                    end else begin
                        if (cpha_q) begin
                            rx_sreg_d = {rx_sreg_q[DATA_W-2:0], MISO};
                        end else if (edge_cnt_q != EDGE_LAST) begin
                            tx_sreg_d = {tx_sreg_q[DATA_W-2:0], 1'b0};
                        end else begin
                            tx_sreg_d = tx_sreg_q;
                        end
                    end
                    if (edge_cnt_q == EDGE_LAST) begin
                        state_d    = S_HOLD;
                        edge_cnt_d = {EW{1'b0}};
                    end else begin
                        state_d = S_XFER;
                    end
                end else begin
                    state_d = S_XFER;
                end
            end
            S_HOLD: begin
                if (tick_s) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    rx_data_d = rx_sreg_q;
                    tx_sreg_d = {DATA_W{1'b0}};
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d   = S_IDLE;
                div_cnt_d = {DIV_W{1'b0}};
                mbr_d     = 1'b0;
            end
        endcase

        ss_n_d = (state_d == S_IDLE);
        idle_d = (state_d != S_XFER);
        busy_d = (state_d != S_IDLE);
        sck_d  = cpol_d ^ mbr_d;
        mosi_d = (state_d == S_IDLE) ? 1'b0 : tx_sreg_d[DATA_W-1];
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= {DIV_W{1'b0}};
            baud_div_q <= {DIV_W{1'b0}};
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            edge_cnt_q <= {EW{1'b0}};
            mbr_q      <= 1'b0;
            tx_sreg_q  <= {DATA_W{1'b0}};
            rx_sreg_q  <= {DATA_W{1'b0}};
            rx_data_q  <= {DATA_W{1'b0}};
            done_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            idle_q     <= 1'b1;
            busy_q     <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            baud_div_q <= baud_div_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            edge_cnt_q <= edge_cnt_d;
            mbr_q      <= mbr_d;
            tx_sreg_q  <= tx_sreg_d;
            rx_sreg_q  <= rx_sreg_d;
            rx_data_q  <= rx_data_d;
            done_q     <= done_d;
            ss_n_q     <= ss_n_d;
            idle_q     <= idle_d;
            busy_q     <= busy_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
        end
    end

    assign M_BaudRate = mbr_q;
    assign idle       = idle_q;
    assign SCK        = sck_q;
    assign MOSI       = mosi_q;
    assign SS_n       = ss_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign rx_data    = rx_data_q;

endmodule

// File: tb/tb_spi_master_seq.sv
// Directed bench for spi_master_seq: table of whole transfers plus hand-written
// sequences for back-to-back start and mid-transfer reset.
module tb_spi_master_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] tx_data;
    logic [7:0] BaudDiv;
    logic       CPOL;
    logic       CPHA;
    logic       miso_drv;
    logic       loopback;
    logic       MISO;
    logic       M_BaudRate;
    logic       idle;
    logic       SCK;
    logic       MOSI;
    logic       SS_n;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;

    int tests  = 0;
    int failed = 0;

    assign MISO = loopback ? MOSI : miso_drv;

    spi_master_seq #(.DATA_W(8), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .BaudDiv(BaudDiv),
        .CPOL(CPOL), .CPHA(CPHA), .MISO(MISO), .M_BaudRate(M_BaudRate), .idle(idle),
        .SCK(SCK), .MOSI(MOSI), .SS_n(SS_n), .busy(busy), .done(done), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] tx;
        logic [7:0] div;
        logic       cpol;
        logic       cpha;
        logic       loop;
        logic [7:0] miso_byte;
        logic [7:0] exp_rx;
        int         exp_ss;
        int         exp_idle;
    } vec_t;

    vec_t vecs[5];

    int         r_ss, r_idle, r_lead, r_half, r_mosi_err;
    logic [7:0] r_rx;
    logic       r_sck_pre, r_sck_post, r_done_after;
    bit         r_timeout;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One transfer from start pulse to done, measuring framing, edges and MOSI stability.
    task automatic run_vec(input vec_t v);
        int   n, lead_i, trail_i, lead_t, trail_t;
        bit   seen, first;
        logic prev_sck, prev_mosi;
        @(negedge clk);
        tx_data = v.tx; BaudDiv = v.div; CPOL = v.cpol; CPHA = v.cpha;
        loopback = v.loop; miso_drv = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r_ss = 0; r_idle = 0; r_mosi_err = 0; r_rx = 8'h00; r_sck_post = 1'bx;
        n = 0; seen = 1'b0; first = 1'b1; lead_i = 0; trail_i = 0; lead_t = -1; trail_t = -1;
        prev_sck = v.cpol; prev_mosi = MOSI;
        while (!seen && n < 5000) begin
            if (first) begin r_sck_pre = SCK; first = 1'b0; end
            if (!SS_n) r_ss++;
            if (!idle) r_idle++;
            if (SCK !== prev_sck) begin
                if (SCK !== v.cpol) begin
                    if (lead_t < 0) lead_t = n;
                    if (lead_i < 8) begin
                        if (!v.cpha && (MOSI !== prev_mosi || MOSI !== v.tx[7-lead_i])) r_mosi_err++;
                        if (!v.loop) miso_drv = v.miso_byte[7-lead_i];
                    end
                    lead_i++;
                end else begin
                    if (trail_t < 0) trail_t = n;
                    if (trail_i < 8) begin
                        if (v.cpha && (MOSI !== prev_mosi || MOSI !== v.tx[7-trail_i])) r_mosi_err++;
                    end
                    trail_i++;
                end
            end
            if (done) begin seen = 1'b1; r_rx = rx_data; r_sck_post = SCK; end
            prev_sck = SCK; prev_mosi = MOSI; n++;
            if (!seen) @(negedge clk);
        end
        r_lead = lead_i; r_half = trail_t - lead_t; r_timeout = !seen;
        @(negedge clk);
        r_done_after = done;
    endtask

    // Sample from the current negedge until done; counts SS_n low cycles and SCK toggles.
    task automatic wait_done(output int ss, output int tog, output logic [7:0] rx, output bit to);
        int   n;
        bit   seen;
        logic ps;
        ss = 0; tog = 0; rx = 8'h00; seen = 1'b0; n = 0; ps = SCK;
        while (!seen && n < 5000) begin
            if (!SS_n) ss++;
            if (SCK !== ps) tog++;
            if (done) begin seen = 1'b1; rx = rx_data; end
            ps = SCK; n++;
            if (!seen) @(negedge clk);
        end
        to = !seen;
    endtask

    initial begin
        int         ss, tog, n, dcnt;
        logic [7:0] rx;
        bit         to;

        vecs[0] = '{8'hA5, 8'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hA5, 18, 16};
        vecs[1] = '{8'h3C, 8'd1, 1'b0, 1'b1, 1'b0, 8'hC3, 8'hC3, 36, 32};
        vecs[2] = '{8'h81, 8'd0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h81, 18, 16};
        vecs[3] = '{8'h81, 8'd0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h81, 18, 16};
        vecs[4] = '{8'h5A, 8'd3, 1'b0, 1'b0, 1'b1, 8'h00, 8'h5A, 72, 64};

        rst = 1'b1; start = 1'b0; tx_data = 8'h00; BaudDiv = 8'd0; CPOL = 1'b0; CPHA = 1'b0;
        miso_drv = 1'b0; loopback = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_M_BaudRate", int'(M_BaudRate), 0);
        check("reset_idle", int'(idle), 1);
        check("reset_SCK", int'(SCK), 0);
        check("reset_MOSI", int'(MOSI), 0);
        check("reset_SS_n", int'(SS_n), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_rx_data", int'(rx_data), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            check($sformatf("v%0d_timeout", i), int'(r_timeout), 0);
            check($sformatf("v%0d_ss_low", i), r_ss, vecs[i].exp_ss);
            check($sformatf("v%0d_idle_low", i), r_idle, vecs[i].exp_idle);
            check($sformatf("v%0d_leading_edges", i), r_lead, 8);
            check($sformatf("v%0d_half_period", i), r_half, int'(vecs[i].div) + 1);
            check($sformatf("v%0d_mosi_stable", i), r_mosi_err, 0);
            check($sformatf("v%0d_rx_data", i), int'(r_rx), int'(vecs[i].exp_rx));
            check($sformatf("v%0d_sck_before", i), int'(r_sck_pre), int'(vecs[i].cpol));
            check($sformatf("v%0d_sck_after", i), int'(r_sck_post), int'(vecs[i].cpol));
            check($sformatf("v%0d_done_pulse", i), int'(r_done_after), 0);
        end

        // start held high; settings change mid-transfer and apply to the follow-on transfer
        @(negedge clk);
        tx_data = 8'hA5; BaudDiv = 8'd0; CPOL = 1'b0; CPHA = 1'b0; loopback = 1'b1; start = 1'b1;
        fork
            begin
                repeat (5) @(negedge clk);
                tx_data = 8'h3C; BaudDiv = 8'd1; CPOL = 1'b1; CPHA = 1'b1;
            end
        join_none
        @(negedge clk);
        wait_done(ss, tog, rx, to);
        check("held_first_timeout", int'(to), 0);
        check("held_first_ss_low", ss, 18);
        check("held_first_sck_toggles", tog, 16);
        check("held_first_rx", int'(rx), 8'hA5);
        @(negedge clk);
        check("held_second_ss_n", int'(SS_n), 0);
        check("held_second_busy", int'(busy), 1);
        check("held_second_sck_cpol", int'(SCK), 1);
        start = 1'b0;
        wait_done(ss, tog, rx, to);
        check("held_second_timeout", int'(to), 0);
        check("held_second_ss_low", ss, 36);
        check("held_second_sck_toggles", tog, 16);
        check("held_second_rx", int'(rx), 8'h3C);

        // reset after the fifth SCK edge aborts without a done pulse
        @(negedge clk);
        tx_data = 8'h96; BaudDiv = 8'd1; CPOL = 1'b0; CPHA = 1'b0; loopback = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tog = 0; n = 0; dcnt = 0;
        begin
            logic ps;
            ps = SCK;
            while (tog < 5 && n < 500) begin
                @(negedge clk);
                if (SCK !== ps) tog++;
                if (done) dcnt++;
                ps = SCK; n++;
            end
        end
        check("rst_reached_edge5", tog, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_SS_n", int'(SS_n), 1);
        check("rst_idle", int'(idle), 1);
        check("rst_M_BaudRate", int'(M_BaudRate), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rx_data", int'(rx_data), 0);
        repeat (60) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        check("rst_no_done", dcnt, 0);
        check("rst_stays_idle", int'(SS_n), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
